mem_stage_async: RTL
====================

// Module: mem_stage_async
// PURPOSE
//  Memory-access stage of the 5-stage MIPS pipeline; successor to the fixed-latency SRAM memory stage.
//  Handles loads that return after a variable latency. The stage holds until data_sram_data_ok arrives.
//  Performs byte/halfword extraction with sign or zero extension.
//  Buffers returned data while WB back-pressures. Supports a pipeline flush: responses still in flight are discarded.
//  Sits between exe_stage (req/addr_ok already done there) and wb_stage; drives hazard and forward paths to id_stage.
// PARAMETERS
//  DATA_W           32   data/address width; byte lanes = DATA_W/8; LW/LH/LB lane select uses addr[1:0]
//  MAX_DISCARD      3    max responses to drop after flushes; discard counter width = $clog2(MAX_DISCARD+1)
//  ES_TO_MS_BUS_WD  75   {load_op[2:0] 74:72, mem_req 71, res_from_mem 70, gr_we 69, dest 68:64, alu_result 63:32, pc 31:0}
//  MS_TO_WS_BUS_WD  70   {gr_we 69, dest 68:64, final_result 63:32, pc 31:0}
//  HAZARD_BUS_WD    8    {ms_valid 7, gr_we 6, dest 5:1, ms_data_pending 0}
// PORTS
//  clk               in   1        clock, all state on posedge
//  resetn            in   1        synchronous reset, active-low
//  ws_allowin        in   1        WB can accept this cycle
//  ms_allowin        out  1        stage can accept from EX
//  es_to_ms_valid    in   1        EX presents an instruction
//  es_to_ms_bus      in   ES_W     EX payload (layout above)
//  ms_to_ws_valid    out  1        instruction leaving to WB
//  ms_to_ws_bus      out  MS_W     WB payload
//  flush             in   1        cancel the instruction held here (exception/eret)
//  data_sram_data_ok in   1        read/write response valid this cycle
//  data_sram_rdata   in   DATA_W   response data, valid with data_ok
//  ms_hazard_bus     out  HZ_W     to id_stage interlock
//  ms_forward        out  DATA_W   ms_final_result forwarding value
//  ms_discard_ovf    out  1        sticky: flush arrived with discard counter saturated (debug)
// BEHAVIOUR
//  Reset (resetn==0 at posedge): ms_valid=0, buf_valid=0, discard_cnt=0, ms_discard_ovf=0.
//   Outputs follow: ms_to_ws_valid=0, ms_allowin=1, hazard bus all-zero.
//  Load: es_to_ms_bus_r <= es_to_ms_bus when es_to_ms_valid && ms_allowin. ms_valid <= es_to_ms_valid && !flush when ms_allowin.
//  rsp_hit = data_sram_data_ok && discard_cnt==0 && ms_valid && mem_req && !buf_valid.
//  ms_ready_go = !mem_req || rsp_hit || buf_valid. Latency: 0 extra cycles when data_ok arrives in the first cycle, else N.
//  ms_allowin = !ms_valid || (ms_ready_go && ws_allowin). ms_to_ws_valid = ms_valid && ms_ready_go && !flush.
//  Buffer: rsp_hit && !ws_allowin -> buf_data<=rdata, buf_valid<=1. Clear on (ms_to_ws_valid && ws_allowin) or flush.
//  Result: raw = buf_valid ? buf_data : rdata; load_op 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU.
//   others: treated as LW.
//  Lane select: byte lane = alu_result[1:0]; half lane = alu_result[1]. Unaligned LH/LW are already excepted in EX.
//  ms_final_result = res_from_mem ? extended(raw) : alu_result.
//  Stores: mem_req=1, res_from_mem=0. The stage still waits for data_ok; the result is alu_result.
//  Flush: ms_valid<=0 next cycle. If ms_valid && mem_req && !buf_valid && !rsp_hit, then discard_cnt+1.
//   If discard_cnt is already MAX_DISCARD, it saturates and ms_discard_ovf is set.
//  Discard: data_sram_data_ok with discard_cnt>0 -> cnt-1. The data is dropped and does not hit the current instruction.
//  Flush and a discarded data_ok in the same cycle: net counter change = (+1 if flush needs a discard) - 1.
//  Stray data_ok (no pending request, cnt==0): ignored.
//  ms_data_pending = ms_valid && res_from_mem && !(rsp_hit || buf_valid). id_stage must stall, not forward, while set.
//  Reset mid-operation clears the counter. The SRAM side is reset in the same cycle, so no stale responses exist.
// STRUCTURE
//  mycpu.h: ES_TO_MS_BUS_WD, MS_TO_WS_BUS_WD, HAZARD_BUS_WD, LOAD_OP_* encodings.
//   exe_stage and id_stage include the same header.
//  Sub-module load_ext (DATA_W param): combinational lane select plus sign/zero extension. It is reused by a future LWL/LWR unit.
//  Remaining logic (valid, buffer, discard counter) is inline in mem_stage_async.
// TESTING
//  1 LW addr 0x100, data_ok in cycle 1 with 0x8899AABB, ws_allowin=1 -> ms_to_ws_valid same cycle, result 0x8899AABB.
//  2 LB addr 0x..3 / LBU addr 0x..3, rdata 0x80FF0011 -> 0xFFFFFF80 / 0x00000080.
//    LH addr 0x..2 -> 0xFFFF80FF.
//  3 LW data_ok after 4 cycles with ws_allowin=0 for 3 more cycles -> buf holds data.
//    Valid stays high and the result is unchanged; leaves when ws_allowin=1 and the next instr is accepted the same cycle.
//  4 Flush during pending LW -> discard_cnt=1.
//    Next instr's LW: first data_ok (0xDEAD) is dropped, second (0xBEEF) is committed.
//  5 Hazard: pending LW to $5 -> hazard bus = {1,1,5,1}; after data_ok, pending bit=0 and ms_forward equals the loaded value.
//  6 resetn=0 mid-wait with discard_cnt=2 -> all state zero next cycle and ms_allowin=1.

Source files
------------

// File: rtl/mem_stage_async_pkg.sv
// Shared definitions for the memory-access stage: bus widths and load-op encodings.
// The same encodings are produced by exe_stage when it builds es_to_ms_bus.
package mem_stage_async_pkg;

  localparam int unsigned ES_BUS_W = 75;
  localparam int unsigned MS_BUS_W = 70;
  localparam int unsigned HZ_BUS_W = 8;
  localparam int unsigned REG_W    = 5;

  typedef enum logic [2:0] {
    LOAD_OP_LW  = 3'd0,
    LOAD_OP_LB  = 3'd1,
    LOAD_OP_LBU = 3'd2,
    LOAD_OP_LH  = 3'd3,
    LOAD_OP_LHU = 3'd4
  } load_op_e;

endpackage

// File: rtl/mem_stage_async_load_ext.sv
// Combinational lane select with sign/zero extension for loaded data.
// Kept standalone so the LWL/LWR merge unit can reuse it.
module load_ext
  import mem_stage_async_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  load_op_e          load_op_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] raw_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = raw_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_v = raw_i[15:8];
      2'd2:    byte_v = raw_i[23:16];
      2'd3:    byte_v = raw_i[31:24];
      default: byte_v = raw_i[7:0];
    endcase
    half_v = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
  end

  always_comb begin
    data_o = raw_i;
    case (load_op_i)
      LOAD_OP_LB:  data_o = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LOAD_OP_LBU: data_o = {{(DATA_W-8){1'b0}}, byte_v};
      LOAD_OP_LH:  data_o = {{(DATA_W-16){half_v[15]}}, half_v};
      LOAD_OP_LHU: data_o = {{(DATA_W-16){1'b0}}, half_v};
      default:     data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_async.sv
// MEM stage with variable-latency data responses: waits for data_ok, buffers data
// under WB back-pressure, and drops responses still owed to flushed instructions.
module mem_stage_async
  import mem_stage_async_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DISCARD     = 3,
  parameter int unsigned ES_TO_MS_BUS_WD = ES_BUS_W,
  parameter int unsigned MS_TO_WS_BUS_WD = MS_BUS_W,
  parameter int unsigned HAZARD_BUS_WD   = HZ_BUS_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       flush,
  input  logic                       data_sram_data_ok,
  input  logic [DATA_W-1:0]          data_sram_rdata,
  output logic [HAZARD_BUS_WD-1:0]   ms_hazard_bus,
  output logic [DATA_W-1:0]          ms_forward,
  output logic                       ms_discard_ovf
);

  localparam int unsigned      CNT_W   = $clog2(MAX_DISCARD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DISCARD);
  localparam int unsigned      F_LO    = 2 * DATA_W;

  logic                       ms_valid_q, ms_valid_d;
  logic [ES_TO_MS_BUS_WD-1:0] es_bus_q, es_bus_d;
  logic                       buf_valid_q, buf_valid_d;
  logic [DATA_W-1:0]          buf_data_q, buf_data_d;
  logic [CNT_W-1:0]           discard_cnt_q, discard_cnt_d;
  logic                       ovf_q, ovf_d;

  load_op_e          load_op;
  logic              mem_req, res_from_mem, gr_we;
  logic [REG_W-1:0]  dest;
  logic [DATA_W-1:0] alu_result, pc;

  assign pc           = es_bus_q[DATA_W-1:0];
  assign alu_result   = es_bus_q[F_LO-1:DATA_W];
  assign dest         = es_bus_q[F_LO+4:F_LO];
  assign gr_we        = es_bus_q[F_LO+5];
  assign res_from_mem = es_bus_q[F_LO+6];
  assign mem_req      = es_bus_q[F_LO+7];
  assign load_op      = load_op_e'(es_bus_q[F_LO+10:F_LO+8]);

  logic rsp_hit, rsp_drop, flush_discard, ms_ready_go, ms_data_pending;
  logic [DATA_W-1:0] raw_data, ext_data, final_result;

  assign rsp_hit       = data_sram_data_ok && (discard_cnt_q == '0) && ms_valid_q
                         && mem_req && !buf_valid_q;
  assign rsp_drop      = data_sram_data_ok && (discard_cnt_q != '0);
  assign flush_discard = flush && ms_valid_q && mem_req && !buf_valid_q && !rsp_hit;

  assign ms_ready_go     = !mem_req || rsp_hit || buf_valid_q;
  assign ms_allowin      = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid  = ms_valid_q && ms_ready_go && !flush;
  assign ms_data_pending = ms_valid_q && res_from_mem && !(rsp_hit || buf_valid_q);

  assign raw_data = buf_valid_q ? buf_data_q : data_sram_rdata;

  load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .load_op_i (load_op),
    .addr_lo_i (alu_result[1:0]),
    .raw_i     (raw_data),
    .data_o    (ext_data)
  );

  assign final_result   = res_from_mem ? ext_data : alu_result;
  assign ms_to_ws_bus   = {gr_we, dest, final_result, pc};
  assign ms_hazard_bus  = {ms_valid_q, gr_we, dest, ms_data_pending};
  assign ms_forward     = final_result;
  assign ms_discard_ovf = ovf_q;

  always_comb begin
    ms_valid_d    = ms_valid_q;
    es_bus_d      = es_bus_q;
    buf_valid_d   = buf_valid_q;
    buf_data_d    = buf_data_q;
    discard_cnt_d = discard_cnt_q;
    ovf_d         = ovf_q;

    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
    if (es_to_ms_valid && ms_allowin) begin
      es_bus_d = es_to_ms_bus;
    end

    if (flush || (ms_to_ws_valid && ws_allowin)) begin
      buf_valid_d = 1'b0;
    end else if (rsp_hit && !ws_allowin) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end

    // A new owed response and a dropped one in the same cycle cancel out.
    if (flush_discard && !rsp_drop) begin
      if (discard_cnt_q != CNT_MAX) begin
        discard_cnt_d = discard_cnt_q + CNT_W'(1);
      end
    end else if (!flush_discard && rsp_drop) begin
      discard_cnt_d = discard_cnt_q - CNT_W'(1);
    end
    if (flush_discard && (discard_cnt_q == CNT_MAX)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q    <= 1'b0;
      es_bus_q      <= '0;
      buf_valid_q   <= 1'b0;
      buf_data_q    <= '0;
      discard_cnt_q <= '0;
      ovf_q         <= 1'b0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      es_bus_q      <= es_bus_d;
      buf_valid_q   <= buf_valid_d;
      buf_data_q    <= buf_data_d;
      discard_cnt_q <= discard_cnt_d;
      ovf_q         <= ovf_d;
    end
  end

endmodule
